// File: rtl/edge_capture_pkg.sv
// edge_capture_pkg: shared definitions for the edge_capture block.
//   - mode_e: per-channel edge-select encoding
//   - parameter limits checked at elaboration by the top
//   - edge_match(): maps a mode and the filtered rise/fall flags to an event
package edge_capture_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int CHANNELS_MIN    = 1;
    localparam int CHANNELS_MAX    = 16;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    function automatic logic edge_match(input logic [1:0] mode,
                                        input logic rise,
                                        input logic fall);
        logic hit;
        case (mode)
            MODE_RISE: hit = rise;
            MODE_FALL: hit = fall;
            MODE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_capture_chan.sv
// edge_capture_chan: one capture channel.
//   Synchroniser -> optional glitch filter -> edge detect -> sticky flags.
//   Build option: EDGE_CAPTURE_FILTER_EN builds the glitch filter; without it
//   the filtered value is the synchronised value and filt_len is unused.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   sig        : raw asynchronous input
//   mode       : edge select (see edge_capture_pkg::mode_e)
//   filt_len   : stable cycles required beyond the first mismatch
//   clr        : write-1-to-clear of pending and ovf
//   pulse      : registered one-cycle event strobe
//   pending    : sticky event flag
//   ovf        : sticky overrun flag
module edge_capture_chan
    import edge_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sig,
    input  logic [1:0]          mode,
    input  logic [FILTER_W-1:0] filt_len,
    input  logic                clr,
    output logic                pulse,
    output logic                pending,
    output logic                ovf
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic                   filt;
    logic                   filt_d;
    logic                   hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= '0;
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig};
    end
    assign sync = sync_ff[SYNC_STAGES-1];

`ifdef EDGE_CAPTURE_FILTER_EN
    logic [FILTER_W-1:0] count;

    // >= rather than == so a filt_len lowered below the running count
    // accepts on the next cycle instead of stalling or wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            filt  <= 1'b0;
        end else if (sync == filt) begin
            count <= '0;
        end else if (count >= filt_len) begin
            filt  <= sync;
            count <= '0;
        end else begin
            count <= count + FILTER_W'(1);
        end
    end
`else
    logic unused_filt_len;
    assign unused_filt_len = ^filt_len;
    assign filt = sync;
`endif

    // Edge is seen between filt and its one-cycle delay, so the strobe
    // lands on the cycle after filt changes.
    always_comb begin
        hit = edge_match(mode, filt & ~filt_d, ~filt & filt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_d  <= 1'b0;
            pulse   <= 1'b0;
            pending <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            filt_d <= filt;
            pulse  <= hit;
            if (clr) begin
                // a coincident event keeps pending set but never counts as overrun
                pending <= hit;
                ovf     <= 1'b0;
            end else if (hit) begin
                pending <= 1'b1;
                if (pending) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/edge_capture.sv
// edge_capture: CHANNELS independent edge-capture channels plus interrupt.
//   Build option: EDGE_CAPTURE_FILTER_EN enables the per-channel glitch filter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   sig_in     : raw asynchronous inputs, one per channel
//   mode       : 2 bits per channel, [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   filt_len   : shared glitch-filter length
//   clr        : per-channel write-1-to-clear of pending/ovf
//   pulse_out  : one-cycle event strobes
//   pending    : sticky event flags
//   ovf        : sticky overrun flags
//   irq        : OR of all pending bits
module edge_capture
    import edge_capture_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   sig_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [FILTER_W-1:0]   filt_len,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   pulse_out,
    output logic [CHANNELS-1:0]   pending,
    output logic [CHANNELS-1:0]   ovf,
    output logic                  irq
);

    if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : gen_bad_channels
        $error("edge_capture: CHANNELS out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : gen_bad_sync
        $error("edge_capture: SYNC_STAGES out of range");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : gen_chan
        edge_capture_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_W    (FILTER_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .sig      (sig_in[i]),
            .mode     (mode[2*i+1:2*i]),
            .filt_len (filt_len),
            .clr      (clr[i]),
            .pulse    (pulse_out[i]),
            .pending  (pending[i]),
            .ovf      (ovf[i])
        );
    end

    assign irq = |pending;

endmodule

// File: tb/tb_edge_capture.sv
module tb_edge_capture;
    import edge_capture_pkg::*;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   sig_in;
    logic [2*CH-1:0] mode;
    logic [FW-1:0]   filt_len;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   pulse_out;
    logic [CH-1:0]   pending;
    logic [CH-1:0]   ovf;
    logic            irq;

    int checks   = 0;
    int failures = 0;

    int first_c  [CH];
    int second_c [CH];
    int cnt      [CH];
    logic pend_first [CH];
    logic irq_first  [CH];

    always #5 clk = ~clk;

    edge_capture #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_W(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .mode      (mode),
        .filt_len  (filt_len),
        .clr       (clr),
        .pulse_out (pulse_out),
        .pending   (pending),
        .ovf       (ovf),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected sig_in-to-pulse latency in cycles
    function automatic int lat(input int fl);
`ifdef EDGE_CAPTURE_FILTER_EN
        return SS + fl + 2;
`else
        return SS + 1;
`endif
    endfunction

    // Runs ncyc cycles, recording pulse statistics per channel. If drop_at > 0,
    // sig_in[drop_ch] falls right after edge drop_at.
    task automatic observe(input int ncyc, input int drop_ch, input int drop_at);
        for (int k = 0; k < CH; k++) begin
            first_c[k] = 0; second_c[k] = 0; cnt[k] = 0;
            pend_first[k] = 1'b0; irq_first[k] = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (drop_at > 0 && c == drop_at) sig_in[drop_ch] = 1'b0;
            for (int k = 0; k < CH; k++) begin
                if (pulse_out[k]) begin
                    cnt[k]++;
                    if (cnt[k] == 1) begin
                        first_c[k] = c;
                        pend_first[k] = pending[k];
                        irq_first[k] = irq;
                    end else if (cnt[k] == 2) begin
                        second_c[k] = c;
                    end
                end
            end
        end
    endtask

    task automatic clear_all();
        clr = '1;
        step();
        clr = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        sig_in   = '0;
        mode     = {CH{MODE_RISE}};
        filt_len = '0;
        clr      = '0;
        #12;
        chk("rst_pulse", pulse_out, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_irq", irq, 0);
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // single rising edge, filt_len=0
        sig_in[0] = 1'b1;
        observe(12, 0, 0);
        chk("rise_first", first_c[0], lat(0));
        chk("rise_count", cnt[0], 1);
        chk("rise_pending", pend_first[0], 1);
        chk("rise_irq", irq_first[0], 1);
        clear_all();
        chk("clr_pending", pending, 0);

        // falling edge in rising mode produces nothing
        sig_in[0] = 1'b0;
        filt_len  = 4'd3;
        observe(20, 0, 0);
        chk("fall_in_rise_mode", cnt[0], 0);

        // 3-cycle glitch with filt_len=3
        sig_in[0] = 1'b1;
        observe(20, 0, 3);
`ifdef EDGE_CAPTURE_FILTER_EN
        chk("glitch_count", cnt[0], 0);
`else
        chk("glitch_count", cnt[0], 1);
`endif
        clear_all();

        // 5-cycle pulse with filt_len=3
        sig_in[0] = 1'b1;
        observe(25, 0, 5);
        chk("pulse5_first", first_c[0], lat(3));
        chk("pulse5_count", cnt[0], 1);
        chk("pulse5_ovf", ovf[0], 0);
        clear_all();

        // both-edge mode, 10-cycle pulse, no clr in between
        filt_len  = 4'd0;
        mode[1:0] = MODE_BOTH;
        sig_in[0] = 1'b1;
        observe(25, 0, 10);
        chk("both_count", cnt[0], 2);
        chk("both_first", first_c[0], lat(0));
        chk("both_spacing", second_c[0] - first_c[0], 10);
        chk("both_ovf", ovf[0], 1);
        chk("both_pending", pending[0], 1);

        // clr coinciding with an event
        sig_in[0] = 1'b1;
        repeat (lat(0) - 1) step();
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("coinc_pulse", pulse_out[0], 1);
        chk("coinc_pending", pending[0], 1);
        chk("coinc_ovf", ovf[0], 0);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("clr_alone_pending", pending[0], 0);
        chk("clr_alone_irq", irq, 0);
        sig_in[0] = 1'b0;
        repeat (10) step();
        clear_all();

        // inputs high through reset release
        mode   = {CH{MODE_RISE}};
        rst_n  = 1'b0;
        sig_in = '1;
        repeat (3) step();
        rst_n = 1'b1;
        observe(15, 0, 0);
        for (int k = 0; k < CH; k++) begin
            chk($sformatf("relhigh_count%0d", k), cnt[k], 1);
            chk($sformatf("relhigh_first%0d", k), first_c[k], lat(0));
        end

        // reset mid-filter count
        sig_in = '0;
        repeat (10) step();
        clear_all();
        filt_len  = 4'd5;
        sig_in[1] = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_pulse", pulse_out, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_irq", irq, 0);
        sig_in = '0;
        repeat (2) step();
        rst_n = 1'b1;
        observe(20, 0, 0);
        chk("midrst_nopulse", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        chk("midrst_irq_after", irq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
